// File: rtl/sync_filter_multi.sv
// rtl/sync_filter_multi.sv - multi-channel synchroniser, glitch filter, edge pulses and counters
module sync_filter_multi #(
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int FILTER_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] async_in,
  input  logic [FILTER_W-1:0] filter_len,
  input  logic [7:0]          cnt_sel,
  input  logic                cnt_clr,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                any_change,
  output logic [CNT_W-1:0]    edge_cnt
);

  localparam logic [FILTER_W-1:0] FCNT_ONE = FILTER_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  // Synchroniser chain registers; no logic may be placed between stages.
  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] chain [STAGES];

  logic [CHANNELS-1:0] chain_out;
  logic [CHANNELS-1:0] stable_next;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;
  logic [FILTER_W-1:0] fcnt      [CHANNELS];
  logic [FILTER_W-1:0] fcnt_next [CHANNELS];
  logic [CNT_W-1:0]    cnt       [CHANNELS];
  logic [CNT_W-1:0]    sel_cnt;

  assign chain_out = chain[STAGES-1];

  // Shift every channel's asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= async_in;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  // Filter decision: accept a change once it has differed for filter_len+1 samples.
  // The >= compare lets a lowered filter_len release a counter already past it.
  always_comb begin
    stable_next = sync_out;
    rise_next   = '0;
    fall_next   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fcnt_next[c] = fcnt[c];
      if (chain_out[c] == sync_out[c]) begin
        fcnt_next[c] = '0;
      end else if (fcnt[c] >= filter_len) begin
        stable_next[c] = chain_out[c];
        fcnt_next[c]   = '0;
        rise_next[c]   = chain_out[c];
        fall_next[c]   = ~chain_out[c];
      end else begin
        fcnt_next[c] = fcnt[c] + FCNT_ONE;
      end
    end
  end

  // Register filtered level, filter counters and the pulses that mark accepted changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_out   <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      any_change <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) fcnt[c] <= '0;
    end else begin
      sync_out   <= stable_next;
      rise_pulse <= rise_next;
      fall_pulse <= fall_next;
      any_change <= |(rise_next | fall_next);
      for (int c = 0; c < CHANNELS; c++) fcnt[c] <= fcnt_next[c];
    end
  end

  // Saturating per-channel edge counters; a clear beats a coincident pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (cnt_clr) begin
          cnt[c] <= '0;
        end else if ((rise_pulse[c] | fall_pulse[c]) && (cnt[c] != CNT_MAX)) begin
          cnt[c] <= cnt[c] + CNT_ONE;
        end
      end
    end
  end

  // Select one counter for readback; out-of-range selects read as zero.
  always_comb begin
    sel_cnt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (cnt_sel == 8'(c)) sel_cnt = cnt[c];
    end
  end

  // Register the selected counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= '0;
    else        edge_cnt <= sel_cnt;
  end

endmodule

// File: doc/sync_filter_multi.md
# sync_filter_multi

Multi-channel clock-domain-crossing input conditioner: each asynchronous input bit passes through a parametrised flip-flop synchroniser chain, then a programmable glitch filter. The block produces a clean level, single-cycle rise/fall pulses, and a saturating per-channel edge counter. It sits at the boundary between external or foreign-clock signals and `clk`-domain logic. It replaces ad-hoc two-register pipelines with a single configurable block.

## Interface
- `CHANNELS`, 4 — number of independent input bits (1..32).
- `STAGES`, 2 — synchroniser flip-flops per channel (2..4).
- `FILTER_W`, 4 — width of the filter length and of each per-channel filter counter.
- `CNT_W`, 16 — width of each per-channel edge counter.

Ports:
- `clk` in 1 — sole clock.
- `rst_n` in 1 — reset, asynchronous assert, active-low; every register in the block clears.
- `async_in` in CHANNELS — asynchronous inputs, unrelated to `clk`.
- `filter_len` in FILTER_W — extra stable cycles required before a level change is accepted; 0 = no filtering. Quasi-static but may change at any time.
- `cnt_sel` in 8 — channel whose edge counter drives `edge_cnt`.
- `cnt_clr` in 1 — synchronous clear of all edge counters.
- `sync_out` out CHANNELS — filtered, synchronised level per channel.
- `rise_pulse` out CHANNELS — one-cycle pulse on an accepted 0→1 change.
- `fall_pulse` out CHANNELS — one-cycle pulse on an accepted 1→0 change.
- `any_change` out 1 — OR of all rise/fall pulses in the same cycle.
- `edge_cnt` out CNT_W — registered copy of the selected channel's edge counter.

## Operation
- Synchroniser: per channel, a shift chain `s[0..STAGES-1]`. `s[0]` samples `async_in` and `chain_out` = `s[STAGES-1]`. No logic between stages; implementation marks the chain registers ASYNC_REG or equivalent.
- Filter: per channel, a register `stable` (drives `sync_out`) and a counter `fcnt` (FILTER_W bits). Each clock:
  - `chain_out == stable`: `fcnt` ← 0.
  - else if `fcnt >= filter_len`: `stable` ← `chain_out`, `fcnt` ← 0, and the matching rise/fall pulse is asserted.
  - else: `fcnt` ← `fcnt+1`.
- Consequence: a change is accepted after `filter_len+1` consecutive differing samples of `chain_out`. Any return to `stable` restarts the count. Using `>=` means lowering `filter_len` mid-count never strands a counter.
- Pulses: `rise_pulse`/`fall_pulse` are registered. Each is high exactly during the first cycle the new `sync_out` value is visible, and is never high on two consecutive cycles for one channel, since a toggle needs at least one full cycle.
- Edge counters: per channel, CNT_W bits. A counter increments by 1 on each rise or fall pulse of its channel and saturates at all-ones. `cnt_clr` sets all counters to 0; when a clear and a pulse occur in the same cycle, the clear wins and the result is 0.
- `edge_cnt` ← counter[`cnt_sel`] each clock. If `cnt_sel >= CHANNELS`, `edge_cnt` ← 0.
- Reset values: all `s`, `stable`, `fcnt`, counters, `sync_out`, `rise_pulse`, `fall_pulse`, `any_change` and `edge_cnt` = 0. Reset asserted mid-filter discards pending changes. After release, an input held at 1 is accepted as a rise like any other change.

## Timing
- Input transition captured by `s[0]` at edge E0: `chain_out` changes after edge E0+STAGES-1.
- `sync_out` and its pulse update at edge E0+STAGES+`filter_len`. Bypass latency is STAGES+1 cycles.
- `edge_cnt` reflects a pulse 2 cycles after the pulse edge: counter update, then output register.
- `edge_cnt` follows a `cnt_sel` change 1 cycle later.
- `filter_len` is sampled every cycle and needs no handshake.
- Capture of a sub-cycle glitch on `async_in` is nondeterministic. The filter guarantees only that a glitch shorter than `filter_len+1` cycles at `chain_out` is never accepted.

## Test plan
- Reset and latency: STAGES=2, `filter_len`=0; raise `async_in[0]` just before edge E0 → `sync_out[0]`=1 and `rise_pulse[0]`=1 for one cycle at E0+2; `any_change`=1 in the same cycle; `edge_cnt`(sel 0)=1 two cycles later.
- Filter reject/accept: `filter_len`=3; 3-cycle high glitch on ch1 → no pulse, `sync_out[1]`=0. 4-cycle high level → rise at capture edge+2+3, and a later fall is filtered identically.
- Mid-count `filter_len` drop: `filter_len`=10, ch2 differs for 5 cycles, then set `filter_len`=2 → accepted on the next edge, since `fcnt`≥2.
- Simultaneous events: ch0 rise and ch3 fall in the same cycle → both pulses, one `any_change` cycle, each counter +1. `cnt_clr` in the pulse cycle → counter 0.
- Saturation and select: CNT_W=4, 20 toggles on ch1 → `edge_cnt`=15. `cnt_sel`=7 with CHANNELS=4 → `edge_cnt`=0.
- Async reset mid-operation: assert `rst_n`=0 between edges while ch0 is mid-filter → all outputs 0 immediately. Release with the input held high → rise after STAGES+1+`filter_len` cycles.
